seq_match_ctrl: RTL and testbench

SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

---
 rtl/seq_match_ctrl.sv | 123 ++++++++++++
 tb/tb_seq_match_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_ctrl.sv
// Serial pattern matcher: shifts bits into an 8-bit history in RUN, pulses match on
// each (overlapping) occurrence of a 1..8 bit pattern, and ends the run at a match threshold.
module seq_match_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_we,
  input  logic [7:0] cfg_pattern,
  input  logic [2:0] cfg_len,
  input  logic [7:0] cfg_thresh,
  input  logic       start,
  input  logic       stop,
  input  logic       a,
  input  logic       a_valid,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic [7:0] match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hist_q, hist_d;
  logic [3:0] fill_q, fill_d;
  logic [7:0] count_q, count_d;
  logic       match_q, match_d;
  logic [7:0] pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic [7:0] thresh_q, thresh_d;

  logic [7:0] hist_upd;
  logic [3:0] fill_upd;
  logic [7:0] len_mask;
  logic       hit;

  // Match is judged on the history and fill as they will be after taking the new bit.
  assign hist_upd = {hist_q[6:0], a};
  assign fill_upd = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
  assign len_mask = 8'hFF >> (3'd7 - len_q);
  assign hit      = (((hist_upd ^ pat_q) & len_mask) == 8'h00) && (fill_upd > {1'b0, len_q});

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    count_d  = count_q;
    match_d  = 1'b0;
    pat_d    = pat_q;
    len_d    = len_q;
    thresh_d = thresh_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            pat_d    = cfg_pattern;
            len_d    = cfg_len;
            thresh_d = cfg_thresh;
          end
          if (start) begin
            state_d = RUN;
            hist_d  = 8'h00;
            fill_d  = 4'd0;
            count_d = 8'h00;
          end
        end
        RUN: begin
          if (a_valid) begin
            hist_d = hist_upd;
            fill_d = fill_upd;
            if (hit) begin
              match_d = 1'b1;
              count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
              if ((thresh_q != 8'h00) && (count_d == thresh_q)) state_d = DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            hist_d  = 8'h00;
            fill_d  = 4'd0;
            count_d = 8'h00;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hist_q   <= 8'h00;
      fill_q   <= 4'd0;
      count_q  <= 8'h00;
      match_q  <= 1'b0;
      pat_q    <= 8'h00;
      len_q    <= 3'd0;
      thresh_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      match_q  <= match_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      thresh_q <= thresh_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign match       = match_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: a bit-list reference model predicts each cycle's
// outputs into a queue, and a monitor pops and compares them on the falling edge.
module tb_seq_match_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       start, stop, a, a_valid;
  logic       busy, done, match;
  logic [7:0] match_count;

  seq_match_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
    .a(a), .a_valid(a_valid), .busy(busy), .done(done), .match(match),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m;
    logic [7:0] c;
    logic       b;
    logic       d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = finished.
  int       m_mode;
  bit       m_bits[$];
  int       m_cnt;
  bit [7:0] m_pat;
  int       m_len;
  int       m_thr;

  task automatic model_reset();
    m_mode = 0;
    m_bits.delete();
    m_cnt  = 0;
    m_pat  = 8'h00;
    m_len  = 0;
    m_thr  = 0;
  endtask

  function automatic bit tail_matches();
    int L = m_len + 1;
    if (m_bits.size() < L) return 1'b0;
    for (int i = 0; i < L; i++)
      if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit we, input bit [7:0] p, input int l, input int t,
                            input bit st, input bit sp, input bit bit_a, input bit av);
    exp_t e;
    bit   m = 1'b0;
    if (sp) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (we) begin
        m_pat = p; m_len = l; m_thr = t;
      end
      if (st) begin
        m_mode = 1; m_bits.delete(); m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (av) begin
        m_bits.push_back(bit_a);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (tail_matches()) begin
          m = 1'b1;
          if (m_cnt < 255) m_cnt++;
          if (m_thr != 0 && m_cnt == m_thr) m_mode = 2;
        end
      end
    end else begin
      if (st) begin
        m_mode = 1; m_bits.delete(); m_cnt = 0;
      end
    end
    e.m = m;
    e.c = m_cnt[7:0];
    e.b = (m_mode == 1);
    e.d = (m_mode == 2);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit we, input bit [7:0] p, input bit [2:0] l, input bit [7:0] t,
                     input bit st, input bit sp, input bit bit_a, input bit av);
    @(negedge clk);
    cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
    start = st; stop = sp; a = bit_a; a_valid = av;
    @(posedge clk);
    model_step(we, p, int'(l), int'(t), st, sp, bit_a, av);
    n_vec++;
  endtask

  task automatic idle_cyc();           cyc(0, 8'h00, 3'd0, 8'h00, 0, 0, 0, 0); endtask
  task automatic cfg(input bit [7:0] p, input bit [2:0] l, input bit [7:0] t);
    cyc(1, p, l, t, 0, 0, 0, 0);
  endtask
  task automatic go();                 cyc(0, 8'h00, 3'd0, 8'h00, 1, 0, 0, 0); endtask
  task automatic sbit(input bit v);    cyc(0, 8'h00, 3'd0, 8'h00, 0, 0, v, 1); endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t got;
      e   = exp_q.pop_front();
      got = {match, match_count, busy, done};
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL cycle_out @%0t: match=%0b count=%0d busy=%0b done=%0b expected match=%0b count=%0d busy=%0b done=%0b",
                 $time, got.m, got.c, got.b, got.d, e.m, e.c, e.b, e.d);
      end
    end
  end

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_match", {31'd0, match}, 32'd0);
    chk("async_rst_count", {24'd0, match_count}, 32'd0);
    chk("async_rst_busy",  {31'd0, busy}, 32'd0);
    chk("async_rst_done",  {31'd0, done}, 32'd0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_thresh = 0;
    start = 0; stop = 0; a = 0; a_valid = 0;
    model_reset();
    #12;
    chk("reset_match", {31'd0, match}, 32'd0);
    chk("reset_count", {24'd0, match_count}, 32'd0);
    chk("reset_busy",  {31'd0, busy}, 32'd0);
    chk("reset_done",  {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_cyc();

    // Overlapping 101 on 10101, unlimited run.
    cfg(8'b101, 3'd2, 8'd0);
    go();
    sbit(1); sbit(0); sbit(1); sbit(0); sbit(1);
    idle_cyc();

    // Same pattern with threshold 2, then bits ignored in DONE.
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0);
    cfg(8'b101, 3'd2, 8'd2);
    go();
    sbit(1); sbit(0); sbit(1); sbit(0); sbit(1);
    sbit(1); sbit(0); sbit(1);
    go();
    sbit(1); sbit(0); sbit(1);

    // Eight-bit pattern of zeros needs a full history.
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0);
    cfg(8'h00, 3'd7, 8'd0);
    go();
    for (int i = 0; i < 9; i++) sbit(0);

    // Stop together with the completing bit; cfg write in RUN is ignored.
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0);
    cfg(8'b101, 3'd2, 8'd0);
    go();
    sbit(1); sbit(0);
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 1, 1);
    idle_cyc();
    go();
    cyc(1, 8'b011, 3'd1, 8'd1, 0, 0, 1, 1);
    sbit(0); sbit(1); sbit(1);

    // Saturation of the count and threshold of 255.
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0);
    cfg(8'h00, 3'd0, 8'd0);
    go();
    for (int i = 0; i < 260; i++) sbit(0);
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0);
    cfg(8'h01, 3'd0, 8'd255);
    go();
    for (int i = 0; i < 258; i++) sbit(1);

    // Asynchronous reset mid-run with three matches, then the default configuration.
    cyc(0, 8'h00, 3'd0, 8'h00, 0, 1, 0, 0);
    cfg(8'b101, 3'd2, 8'd0);
    go();
    sbit(1); sbit(0); sbit(1); sbit(0); sbit(1); sbit(0); sbit(1);
    async_reset_pulse();
    idle_cyc();
    go();
    sbit(0);
    sbit(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit       we = ($urandom_range(0, 99) < 8);
      bit [7:0] p  = 8'($urandom);
      bit [2:0] l  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      bit [7:0] t  = 8'($urandom_range(0, 6));
      bit       st = ($urandom_range(0, 99) < 5);
      bit       sp = ($urandom_range(0, 99) < 2);
      bit       b  = 1'($urandom);
      bit       av = ($urandom_range(0, 99) < 75);
      cyc(we, p, l, t, st, sp, b, av);
    end

    idle_cyc();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
